// File: rtl/conv_buf_pkg.sv
// Shared types and elaboration helpers for the convolution operand buffer
// and the window scanning blocks built on it.
package conv_buf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_IMG = 3'd1,
        ST_LOAD_FLT = 3'd2,
        ST_STREAM   = 3'd3,
        ST_DONE     = 3'd4
    } conv_state_e;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int idx_w(input int n);
        return (n <= 32'sd1) ? 32'sd1 : $clog2(n);
    endfunction

    // Flat element slot of (row i, column j) inside a K x K tile.
    function automatic int pack_idx(input int i, input int j, input int k);
        return i * k + j;
    endfunction

endpackage

// File: rtl/window_scan_ctr.sv
// Row-major top-left position counter for K x K windows sliding over an image;
// holds at the final position so the last window stays addressable.
module window_scan_ctr #(
    parameter int ROW_MAX = 1,
    parameter int COL_MAX = 1,
    parameter int RW      = 2,
    parameter int CW      = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          wrap,
    output logic          last_row
);

    localparam logic [RW-1:0] ROW_END = RW'(ROW_MAX);
    localparam logic [CW-1:0] COL_END = CW'(COL_MAX);

    logic [RW-1:0] row_r;
    logic [CW-1:0] col_r;
    logic          wrap_s;
    logic          last_row_s;

    assign wrap_s     = (col_r == COL_END);
    assign last_row_s = (row_r == ROW_END);

    // Position register: clear restarts the scan, advance steps one window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_r <= '0;
            col_r <= '0;
        end else if (clear) begin
            row_r <= '0;
            col_r <= '0;
        end else if (advance && !(wrap_s && last_row_s)) begin
            if (wrap_s) begin
                col_r <= '0;
                row_r <= row_r + RW'(1'b1);
            end else begin
                col_r <= col_r + CW'(1'b1);
            end
        end
    end

    assign row      = row_r;
    assign col      = col_r;
    assign wrap     = wrap_s;
    assign last_row = last_row_s;

endmodule

// File: rtl/conv_operand_buffer.sv
// Loads an image and a filter over a valid/ready stream, then presents every
// K x K window of the image together with the filter to the MAC array.
module conv_operand_buffer
    import conv_buf_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_H  = 4,
    parameter int IMG_W  = 4,
    parameter int K      = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic [K*K*DATA_W-1:0]      win_data,
    output logic [K*K*DATA_W-1:0]      flt_data,
    output logic [idx_w(IMG_H)-1:0]    win_row,
    output logic [idx_w(IMG_W)-1:0]    win_col,
    output logic                       win_last,
    output logic                       busy,
    output logic                       done
);

    localparam int IMG_N = IMG_H * IMG_W;
    localparam int FLT_N = K * K;
    localparam int LD_W  = idx_w(IMG_N);
    localparam int FLT_W = idx_w(FLT_N);
    localparam int RW    = idx_w(IMG_H);
    localparam int CW    = idx_w(IMG_W);

    localparam logic [LD_W-1:0] IMG_LAST = LD_W'(IMG_N - 32'sd1);
    localparam logic [LD_W-1:0] FLT_LAST = LD_W'(FLT_N - 32'sd1);

    if (K > IMG_H || K > IMG_W) begin : g_bad_k
        $error("conv_operand_buffer: K must not exceed IMG_H or IMG_W");
    end

    conv_state_e       state_r;
    conv_state_e       state_nxt_s;
    logic [LD_W-1:0]   load_idx_r;
    logic [DATA_W-1:0] img_r [IMG_N];
    logic [DATA_W-1:0] flt_r [FLT_N];
    logic              in_ready_r;
    logic              win_valid_r;
    logic              busy_r;
    logic              done_r;

    logic              img_hs_s;
    logic              flt_hs_s;
    logic              img_last_s;
    logic              flt_last_s;
    logic              win_hs_s;
    logic [RW-1:0]     scan_row_s;
    logic [CW-1:0]     scan_col_s;
    logic              scan_wrap_s;
    logic              scan_last_row_s;
    logic              scan_last_s;

    assign img_hs_s    = (state_r == ST_LOAD_IMG) && in_valid && in_ready_r;
    assign flt_hs_s    = (state_r == ST_LOAD_FLT) && in_valid && in_ready_r;
    assign img_last_s  = img_hs_s && (load_idx_r == IMG_LAST);
    assign flt_last_s  = flt_hs_s && (load_idx_r == FLT_LAST);
    assign win_hs_s    = (state_r == ST_STREAM) && win_valid_r && win_ready;
    assign scan_last_s = scan_wrap_s && scan_last_row_s;

    // Job sequencing: load image, load filter, stream windows, report done.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_LOAD_IMG;
                else       state_nxt_s = ST_IDLE;
            end
            ST_LOAD_IMG: begin
                if (img_last_s) state_nxt_s = ST_LOAD_FLT;
                else            state_nxt_s = ST_LOAD_IMG;
            end
            ST_LOAD_FLT: begin
                if (flt_last_s) state_nxt_s = ST_STREAM;
                else            state_nxt_s = ST_LOAD_FLT;
            end
            ST_STREAM: begin
                if (win_hs_s && scan_last_s) state_nxt_s = ST_DONE;
                else                         state_nxt_s = ST_STREAM;
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State and handshake flags are registered from the next state so that
    // they line up exactly with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            win_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == ST_LOAD_IMG) || (state_nxt_s == ST_LOAD_FLT);
            win_valid_r <= (state_nxt_s == ST_STREAM);
            busy_r      <= (state_nxt_s != ST_IDLE);
            done_r      <= (state_nxt_s == ST_DONE);
        end
    end

    // Shared load pointer; restarts for each of the two load phases.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_idx_r <= '0;
        end else if ((state_r == ST_IDLE) && start) begin
            load_idx_r <= '0;
        end else if (img_last_s || flt_last_s) begin
            load_idx_r <= '0;
        end else if (img_hs_s || flt_hs_s) begin
            load_idx_r <= load_idx_r + LD_W'(1'b1);
        end
    end

    // Operand storage; contents survive job completion until the next load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 32'sd0; n < IMG_N; n++) img_r[n] <= '0;
            for (int n = 32'sd0; n < FLT_N; n++) flt_r[n] <= '0;
        end else if (img_hs_s) begin
            img_r[load_idx_r] <= in_data;
        end else if (flt_hs_s) begin
            flt_r[load_idx_r[FLT_W-1:0]] <= in_data;
        end
    end

    window_scan_ctr #(
        .ROW_MAX (IMG_H - K),
        .COL_MAX (IMG_W - K),
        .RW      (RW),
        .CW      (CW)
    ) u_scan (
        .clk      (clk),
        .rst      (rst),
        .clear    (flt_last_s),
        .advance  (win_hs_s),
        .row      (scan_row_s),
        .col      (scan_col_s),
        .wrap     (scan_wrap_s),
        .last_row (scan_last_row_s)
    );

    // Window tap (i,j) reads image pixel (row+i, col+j); filter is a fixed map.
    for (genvar gi = 32'sd0; gi < K; gi++) begin : g_tap_row
        for (genvar gj = 32'sd0; gj < K; gj++) begin : g_tap_col
            logic [LD_W-1:0] sel_s;
            assign sel_s = LD_W'((int'(scan_row_s) + gi) * IMG_W + int'(scan_col_s) + gj);
            assign win_data[pack_idx(gi, gj, K)*DATA_W +: DATA_W] = img_r[sel_s];
            assign flt_data[pack_idx(gi, gj, K)*DATA_W +: DATA_W] = flt_r[pack_idx(gi, gj, K)];
        end
    end

    assign in_ready  = in_ready_r;
    assign win_valid = win_valid_r;
    assign win_row   = scan_row_s;
    assign win_col   = scan_col_s;
    assign win_last  = scan_last_s && win_valid_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_conv_operand_buffer.sv
// Randomised bench for conv_operand_buffer: three instances (default 4x4/K3,
// 5x6/K2, 3x3/K3) checked against an array-based window model.
module tb_conv_operand_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_v     [3];
    logic       in_valid_v  [3];
    logic       win_ready_v [3];
    logic [7:0] in_data_v   [3];
    logic       in_ready_v  [3];
    logic       win_valid_v [3];
    logic       win_last_v  [3];
    logic       busy_v      [3];
    logic       done_v      [3];
    logic [71:0] win_v      [3];
    logic [71:0] flt_v      [3];
    logic [2:0]  row_v      [3];
    logic [2:0]  col_v      [3];

    logic [71:0] win0, flt0, win2, flt2;
    logic [31:0] win1, flt1;
    logic [1:0]  row0, col0, row2, col2;
    logic [2:0]  row1, col1;

    conv_operand_buffer #(.DATA_W(8), .IMG_H(4), .IMG_W(4), .K(3)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .in_valid(in_valid_v[0]),
        .in_ready(in_ready_v[0]), .in_data(in_data_v[0]), .win_valid(win_valid_v[0]),
        .win_ready(win_ready_v[0]), .win_data(win0), .flt_data(flt0), .win_row(row0),
        .win_col(col0), .win_last(win_last_v[0]), .busy(busy_v[0]), .done(done_v[0]));

    conv_operand_buffer #(.DATA_W(8), .IMG_H(5), .IMG_W(6), .K(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .in_valid(in_valid_v[1]),
        .in_ready(in_ready_v[1]), .in_data(in_data_v[1]), .win_valid(win_valid_v[1]),
        .win_ready(win_ready_v[1]), .win_data(win1), .flt_data(flt1), .win_row(row1),
        .win_col(col1), .win_last(win_last_v[1]), .busy(busy_v[1]), .done(done_v[1]));

    conv_operand_buffer #(.DATA_W(8), .IMG_H(3), .IMG_W(3), .K(3)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .in_valid(in_valid_v[2]),
        .in_ready(in_ready_v[2]), .in_data(in_data_v[2]), .win_valid(win_valid_v[2]),
        .win_ready(win_ready_v[2]), .win_data(win2), .flt_data(flt2), .win_row(row2),
        .win_col(col2), .win_last(win_last_v[2]), .busy(busy_v[2]), .done(done_v[2]));

    assign win_v[0] = win0;
    assign flt_v[0] = flt0;
    assign row_v[0] = {1'b0, row0};
    assign col_v[0] = {1'b0, col0};
    assign win_v[1] = {40'd0, win1};
    assign flt_v[1] = {40'd0, flt1};
    assign row_v[1] = row1;
    assign col_v[1] = col1;
    assign win_v[2] = win2;
    assign flt_v[2] = flt2;
    assign row_v[2] = {1'b0, row2};
    assign col_v[2] = {1'b0, col2};

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt [3] = '{0, 0, 0};
    int img_m [64];
    int flt_m [16];

    // Count done pulses per instance, sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++)
            if (done_v[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
    end

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int p_h(input int s);
        return (s == 0) ? 4 : (s == 1) ? 5 : 3;
    endfunction
    function automatic int p_w(input int s);
        return (s == 0) ? 4 : (s == 1) ? 6 : 3;
    endfunction
    function automatic int p_k(input int s);
        return (s == 1) ? 2 : 3;
    endfunction

    // Reference window at top-left (r,c): element (i,j) = image[r+i][c+j].
    function automatic logic [71:0] exp_win(input int s, input int r, input int c);
        logic [71:0] v = '0;
        int k = p_k(s);
        int w = p_w(s);
        for (int i = 0; i < k; i++)
            for (int j = 0; j < k; j++)
                v[(i*k+j)*8 +: 8] = 8'(img_m[(r+i)*w + c + j]);
        return v;
    endfunction

    function automatic logic [71:0] exp_flt(input int s);
        logic [71:0] v = '0;
        int k = p_k(s);
        for (int n = 0; n < k*k; n++) v[n*8 +: 8] = 8'(flt_m[n]);
        return v;
    endfunction

    task automatic load_default();
        int img_d [16] = '{137,139,1,162,36,206,231,205,13,154,102,209,122,40,57,200};
        int flt_d [9]  = '{165,213,198,124,79,77,111,172,162};
        for (int n = 0; n < 16; n++) img_m[n] = img_d[n];
        for (int n = 0; n < 9; n++)  flt_m[n] = flt_d[n];
    endtask

    // gaps: 0 none, 1 toggle, 2 random. pc selects plan constant spot checks.
    task automatic run_job(input int sel, input int gaps, input int bp_w, input int bp_n,
                           input bit rnd_stall, input int start_w, input int abort_w, input int pc);
        int h = p_h(sel), w = p_w(sel), k = p_k(sel);
        int npix = h*w, nbeat = npix + k*k, ncol = w - k + 1;
        int nwin = (h - k + 1) * ncol;
        int b = 0, cyc = 0, d0, stall, t, r, c;
        bit acc, ph = 1'b1;
        logic [71:0] ew;
        d0 = done_cnt[sel];
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v[sel] = 1'b0;
        check("start_busy", busy_v[sel], 1);
        while (b < nbeat && cyc < 1000) begin
            case (gaps)
                1:       in_valid_v[sel] = ph;
                2:       in_valid_v[sel] = 1'($urandom_range(0, 1));
                default: in_valid_v[sel] = 1'b1;
            endcase
            ph = !ph;
            in_data_v[sel] = (b < npix) ? 8'(img_m[b]) : 8'(flt_m[b-npix]);
            acc = in_valid_v[sel] && in_ready_v[sel];
            if (acc && b == nbeat-1) check("pre_valid", win_valid_v[sel], 0);
            @(negedge clk);
            cyc++;
            if (acc) b++;
        end
        in_valid_v[sel] = 1'b0;
        if (b < nbeat) begin
            check("load_timeout", b, nbeat);
            return;
        end
        check("first_valid", win_valid_v[sel], 1);
        check("stream_in_ready", in_ready_v[sel], 0);
        win_ready_v[sel] = 1'b1;
        for (int wi = 0; wi < nwin; wi++) begin
            r = wi / ncol;
            c = wi % ncol;
            ew = exp_win(sel, r, c);
            t = 0;
            while (win_valid_v[sel] !== 1'b1 && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (win_valid_v[sel] !== 1'b1) begin
                check("win_timeout", win_valid_v[sel], 1);
                return;
            end
            check("win_row", row_v[sel], r);
            check("win_col", col_v[sel], c);
            check("win_data", win_v[sel], ew);
            check("win_last", win_last_v[sel], (wi == nwin-1) ? 1 : 0);
            check("flt_data", flt_v[sel], exp_flt(sel));
            if (pc == 1 && wi == 0) begin
                check("w00_e0", win_v[sel][7:0], 137);
                check("w00_e4", win_v[sel][39:32], 206);
                check("flt_e0", flt_v[sel][7:0], 165);
                check("flt_e8", flt_v[sel][71:64], 162);
            end
            if (pc == 1 && wi == 3) begin
                check("w11_e0", win_v[sel][7:0], 206);
                check("w11_e8", win_v[sel][71:64], 200);
            end
            if (pc == 2 && wi == nwin-1) begin
                check("last_row", row_v[sel], 3);
                check("last_col", col_v[sel], 4);
                check("last_e0", win_v[sel][7:0], 22);
                check("last_e3", win_v[sel][31:24], 29);
            end
            if (wi == start_w) start_v[sel] = 1'b1;
            stall = (wi == bp_w) ? bp_n : (rnd_stall ? int'($urandom_range(0, 2)) : 0);
            if (stall > 0) begin
                win_ready_v[sel] = 1'b0;
                repeat (stall) begin
                    @(negedge clk);
                    check("stall_valid", win_valid_v[sel], 1);
                    check("stall_data", win_v[sel], ew);
                    check("stall_row", row_v[sel], r);
                    check("stall_col", col_v[sel], c);
                end
                win_ready_v[sel] = 1'b1;
            end
            if (wi == abort_w) begin
                @(posedge clk);
                #2 rst = 1'b0;
                #1;
                check("rst_valid", win_valid_v[sel], 0);
                check("rst_busy", busy_v[sel], 0);
                check("rst_in_ready", in_ready_v[sel], 0);
                check("rst_last", win_last_v[sel], 0);
                check("rst_done", done_v[sel], 0);
                check("rst_win", win_v[sel], 0);
                check("rst_flt", flt_v[sel], 0);
                check("rst_pos", {row_v[sel], col_v[sel]}, 0);
                start_v[sel] = 1'b0;
                win_ready_v[sel] = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                repeat (2) @(negedge clk);
                check("rst_stays_idle", busy_v[sel], 0);
                return;
            end
            @(negedge clk);
            start_v[sel] = 1'b0;
        end
        check("done_pulse", done_v[sel], 1);
        check("done_valid", win_valid_v[sel], 0);
        check("done_busy", busy_v[sel], 1);
        win_ready_v[sel] = 1'b0;
        @(negedge clk);
        check("done_clear", done_v[sel], 0);
        check("idle_busy", busy_v[sel], 0);
        check("done_count", done_cnt[sel] - d0, 1);
    endtask

    // Load-side traffic in IDLE must be refused and leave storage untouched.
    task automatic idle_probe(input int sel);
        logic [71:0] ew = exp_win(sel, p_h(sel) - p_k(sel), p_w(sel) - p_k(sel));
        repeat (4) begin
            in_valid_v[sel] = 1'b1;
            in_data_v[sel]  = 8'($urandom);
            @(negedge clk);
            check("idle_in_ready", in_ready_v[sel], 0);
        end
        in_valid_v[sel] = 1'b0;
        @(negedge clk);
        check("idle_win", win_v[sel], ew);
        check("idle_flt", flt_v[sel], exp_flt(sel));
        check("idle_busy2", busy_v[sel], 0);
    endtask

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            in_valid_v[i] = 1'b0;
            win_ready_v[i] = 1'b0;
            in_data_v[i] = 8'd0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset_in_ready", in_ready_v[i], 0);
            check("reset_valid", win_valid_v[i], 0);
            check("reset_busy", busy_v[i], 0);
            check("reset_done", done_v[i], 0);
            check("reset_last", win_last_v[i], 0);
            check("reset_win", win_v[i], 0);
            check("reset_flt", flt_v[i], 0);
            check("reset_pos", {row_v[i], col_v[i]}, 0);
        end
        rst = 1'b1;
        @(negedge clk);

        load_default();
        run_job(0, 0, -1, 0, 1'b0, -1, -1, 1);
        idle_probe(0);
        run_job(0, 0, 1, 3, 1'b0, -1, -1, 1);
        run_job(0, 1, -1, 0, 1'b0, 1, -1, 1);
        run_job(0, 0, -1, 0, 1'b0, -1, 1, 0);
        run_job(0, 0, -1, 0, 1'b0, -1, -1, 1);

        for (int rep = 0; rep < 3; rep++) begin
            for (int n = 0; n < 16; n++) img_m[n] = int'($urandom_range(0, 255));
            for (int n = 0; n < 9; n++)  flt_m[n] = int'($urandom_range(0, 255));
            run_job(0, 2, -1, 0, 1'b1, -1, -1, 0);
        end

        for (int n = 0; n < 30; n++) img_m[n] = n;
        for (int n = 0; n < 4; n++)  flt_m[n] = 30 + n;
        run_job(1, 0, -1, 0, 1'b1, 2, -1, 2);

        for (int n = 0; n < 9; n++) img_m[n] = int'($urandom_range(0, 255));
        for (int n = 0; n < 9; n++) flt_m[n] = int'($urandom_range(0, 255));
        run_job(2, 2, -1, 0, 1'b0, 0, -1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
